// File: rtl/fb_mem_arbiter.sv
// Round-robin arbiter sharing the frame-buffer memory port between drawing
// engines. The owner's request is forwarded combinationally to memory. Each
// grant is limited to MAX_BURST beats. A tag FIFO remembers which requester
// issued each outstanding read, so returned words can be strobed back to the
// requester that asked for them.
module fb_mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 64,
    parameter int TAG_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_rts,
    output logic [NUM_REQ-1:0]      req_rtr,
    input  logic [NUM_REQ*4-1:0]    req_wben,
    input  logic [NUM_REQ*16-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_op,
    output logic [31:0]             bcast_data,
    output logic [NUM_REQ-1:0]      bcast_xfc,
    output logic                    mem_rts,
    input  logic                    mem_rtr,
    output logic [3:0]              mem_wben,
    output logic [15:0]             mem_addr,
    output logic [31:0]             mem_data,
    output logic                    mem_op,
    input  logic                    mem_rd_valid,
    input  logic [31:0]             mem_rd_data,
    output logic                    rd_underflow
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W  = $clog2(TAG_DEPTH + 1);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Arbiter state
    logic [0:0]        state_reg, state_next;
    logic [IDX_W-1:0]  owner_reg, owner_next;
    logic [IDX_W-1:0]  last_owner_reg, last_owner_next;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;

    // Tag FIFO state
    logic [IDX_W-1:0]  tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    // Per-requester field views, unpacked so the owner can index them
    logic [3:0]        wben_arr [NUM_REQ];
    logic [15:0]       addr_arr [NUM_REQ];
    logic [31:0]       data_arr [NUM_REQ];

    logic              grant;
    logic              owner_rts;
    logic              owner_op;
    logic              blocked;
    logic              xfc;
    logic              tag_full;
    logic              tag_empty;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  head_tag;
    logic [NUM_REQ-1:0] head_onehot;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign wben_arr[gi]    = req_wben[4*gi +: 4];
            assign addr_arr[gi]    = req_addr[16*gi +: 16];
            assign data_arr[gi]    = req_data[32*gi +: 32];
            assign req_rtr[gi]     = grant && (owner_reg == IDX_W'(gi)) && mem_rtr && !blocked;
            assign head_onehot[gi] = (head_tag == IDX_W'(gi));
        end
    endgenerate

    assign grant     = (state_reg == ST_GRANT);
    assign owner_rts = req_rts[owner_reg];
    assign owner_op  = req_op[owner_reg];
    assign tag_full  = (count_reg == CNT_W'(TAG_DEPTH));
    assign tag_empty = (count_reg == '0);
    // A read is held off while the FIFO is full, even if a pop happens now
    assign blocked   = grant && owner_op && tag_full;
    assign mem_rts   = grant && owner_rts && !blocked;
    assign xfc       = mem_rts && mem_rtr;
    assign push      = xfc && mem_op;
    assign pop       = mem_rd_valid && !tag_empty;
    assign head_tag  = tag_mem[rd_ptr_reg];

    // Forward the owner's fields to memory; all zero when nobody owns the port
    always_comb begin
        mem_wben = '0;
        mem_addr = '0;
        mem_data = '0;
        mem_op   = 1'b0;
        if (grant) begin
            mem_wben = wben_arr[owner_reg];
            mem_addr = addr_arr[owner_reg];
            mem_data = data_arr[owner_reg];
            mem_op   = owner_op;
        end
    end

    // Round-robin pick: first rts at or after last_owner+1; lowest offset wins
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_owner_reg) + k) % NUM_REQ);
            if (req_rts[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Grant FSM and burst length tracking
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        beat_cnt_next   = beat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next      = ST_GRANT;
                    owner_next      = pick_idx;
                    last_owner_next = pick_idx;
                    beat_cnt_next   = '0;
                end
            end
            default: begin
                if (xfc) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
                if (!owner_rts || (xfc && beat_cnt_reg == BEAT_W'(MAX_BURST - 1))) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    // Tag FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Tag storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= owner_reg;
        end
    end

    // State registers, FIFO control and registered read-return outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            beat_cnt_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            bcast_data     <= '0;
            bcast_xfc      <= '0;
            rd_underflow   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            beat_cnt_reg   <= beat_cnt_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            if (mem_rd_valid) begin
                bcast_data <= mem_rd_data;
            end
            bcast_xfc <= pop ? head_onehot : '0;
            if (mem_rd_valid && tag_empty) begin
                rd_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: a vector table for forwarding and
// arbitration, and hand-written sequences for bursts, reads and reset.
module tb_fb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_rts;
    logic [3:0]  req_rtr;
    logic [15:0] req_wben;
    logic [63:0] req_addr;
    logic [127:0] req_data;
    logic [3:0]  req_op;
    logic [31:0] bcast_data;
    logic [3:0]  bcast_xfc;
    logic        mem_rts;
    logic        mem_rtr;
    logic [3:0]  mem_wben;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_op;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        rd_underflow;

    int tests;
    int fails;

    fb_mem_arbiter #(.NUM_REQ(4), .MAX_BURST(64), .TAG_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_rts      (req_rts),
        .req_rtr      (req_rtr),
        .req_wben     (req_wben),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_op       (req_op),
        .bcast_data   (bcast_data),
        .bcast_xfc    (bcast_xfc),
        .mem_rts      (mem_rts),
        .mem_rtr      (mem_rtr),
        .mem_wben     (mem_wben),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_op       (mem_op),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .rd_underflow (rd_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        mem_rtr;
        logic [3:0]  rts;
        logic [15:0] a1;
        logic        exp_rts;
        logic [3:0]  exp_rtr;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic set_a1(input logic [15:0] a1);
        req_addr = {16'h0300, 16'h0200, a1, 16'h0A00};
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_mem_rts"}, {31'd0, mem_rts}, 32'd0);
        chk({name, "_req_rtr"}, {28'd0, req_rtr}, 32'd0);
        chk({name, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    endtask

    int cnt;
    logic [3:0] exp_oh;

    initial begin
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        req_rts      = 4'b0000;
        req_op       = 4'b0000;
        req_wben     = 16'hFFFF;
        req_data     = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};
        set_a1(16'h0100);
        mem_rtr      = 1'b1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 32'h0;

        // Vector table: single writer, backpressure, rotation and bubbles
        vecs[0]  = '{1'b1, 4'b0000, 16'h0100, 1'b0, 4'b0000, 16'h0000};
        vecs[1]  = '{1'b1, 4'b0010, 16'h0100, 1'b0, 4'b0000, 16'h0000};
        vecs[2]  = '{1'b1, 4'b0010, 16'h0100, 1'b1, 4'b0010, 16'h0100};
        vecs[3]  = '{1'b1, 4'b0010, 16'h0101, 1'b1, 4'b0010, 16'h0101};
        vecs[4]  = '{1'b0, 4'b0010, 16'h0102, 1'b1, 4'b0000, 16'h0102};
        vecs[5]  = '{1'b1, 4'b0010, 16'h0102, 1'b1, 4'b0010, 16'h0102};
        vecs[6]  = '{1'b1, 4'b0000, 16'h0103, 1'b0, 4'b0010, 16'h0103};
        vecs[7]  = '{1'b1, 4'b0000, 16'h0103, 1'b0, 4'b0000, 16'h0000};
        vecs[8]  = '{1'b1, 4'b1010, 16'h0103, 1'b0, 4'b0000, 16'h0000};
        vecs[9]  = '{1'b1, 4'b1010, 16'h0103, 1'b1, 4'b1000, 16'h0300};
        vecs[10] = '{1'b1, 4'b0010, 16'h0103, 1'b0, 4'b1000, 16'h0300};
        vecs[11] = '{1'b1, 4'b0010, 16'h0104, 1'b0, 4'b0000, 16'h0000};
        vecs[12] = '{1'b1, 4'b0010, 16'h0200, 1'b1, 4'b0010, 16'h0200};
        vecs[13] = '{1'b1, 4'b0000, 16'h0200, 1'b0, 4'b0010, 16'h0200};

        // Reset values
        @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_bcast_xfc", {28'd0, bcast_xfc}, 32'd0);
        chk("reset_bcast_data", bcast_data, 32'd0);
        chk("reset_underflow", {31'd0, rd_underflow}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            mem_rtr = vecs[i].mem_rtr;
            req_rts = vecs[i].rts;
            set_a1(vecs[i].a1);
            @(negedge clk);
            chk($sformatf("vec%0d_mem_rts", i), {31'd0, mem_rts}, {31'd0, vecs[i].exp_rts});
            chk($sformatf("vec%0d_req_rtr", i), {28'd0, req_rtr}, {28'd0, vecs[i].exp_rtr});
            chk($sformatf("vec%0d_mem_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].exp_addr});
        end

        // Contention: all four requesters held, bursts capped at 64 beats
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        req_rts = 4'b1111;
        mem_rtr = 1'b1;
        @(negedge clk);
        chk("cont_first_bubble", {28'd0, req_rtr, 3'd0, mem_rts}, 32'd0);
        for (int g = 0; g < 5; g++) begin
            exp_oh = 4'b0001 << (g % 4);
            cnt = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (mem_rts && req_rtr == exp_oh) cnt++;
                else break;
            end
            chk($sformatf("cont_grant%0d_beats", g), cnt, 32'd64);
            chk($sformatf("cont_grant%0d_bubble", g), {28'd0, req_rtr, 3'd0, mem_rts}, 32'd0);
        end
        req_rts = 4'b0000;

        // Read routing: req 2 fills the tag FIFO, 5th read waits for a pop
        @(posedge clk); #1;
        req_rts = 4'b0100;
        req_op  = 4'b0100;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rd_issue%0d", k), {28'd0, req_rtr, 3'd0, mem_rts}, {28'd0, 4'b0100, 4'b0001});
        end
        @(negedge clk);
        chk("rd_blocked", {28'd0, req_rtr, 3'd0, mem_rts}, 32'd0);
        @(posedge clk); #1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_blocked_during_pop", {31'd0, mem_rts}, 32'd0);
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("rd_ret_xfc", {28'd0, bcast_xfc}, 32'h4);
        chk("rd_ret_data", bcast_data, 32'hDEADBEEF);
        chk("rd_fifth_issues", {31'd0, mem_rts}, 32'd1);
        @(posedge clk); #1;
        req_rts = 4'b0000;
        @(negedge clk);
        chk("rd_strobe_one_cycle", {28'd0, bcast_xfc}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hA0000000 + k;
            @(posedge clk); #1;
            mem_rd_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("rd_drain%0d_xfc", k), {28'd0, bcast_xfc}, 32'h4);
            chk($sformatf("rd_drain%0d_data", k), bcast_data, 32'hA0000000 + k);
        end

        // Interleaved reads: req 0 then req 3, then an unmatched return
        @(posedge clk); #1;
        req_rts = 4'b0001;
        req_op  = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("il_req0_issue", {28'd0, req_rtr, 3'd0, mem_rts}, {28'd0, 4'b0001, 4'b0001});
        @(posedge clk); #1;
        req_rts = 4'b0000;
        @(posedge clk); #1;
        req_rts = 4'b1000;
        req_op  = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        chk("il_req3_issue", {28'd0, req_rtr, 3'd0, mem_rts}, {28'd0, 4'b1000, 4'b0001});
        @(posedge clk); #1;
        req_rts = 4'b0000;
        req_op  = 4'b0000;
        @(posedge clk); #1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'h11111111;
        @(posedge clk); #1;
        mem_rd_data  = 32'h22222222;
        @(negedge clk);
        chk("il_ret0_xfc", {28'd0, bcast_xfc}, 32'h1);
        chk("il_ret0_data", bcast_data, 32'h11111111);
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("il_ret1_xfc", {28'd0, bcast_xfc}, 32'h8);
        chk("il_ret1_data", bcast_data, 32'h22222222);
        chk("il_no_underflow_yet", {31'd0, rd_underflow}, 32'd0);
        @(posedge clk); #1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'h33333333;
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("uf_flag", {31'd0, rd_underflow}, 32'd1);
        chk("uf_no_strobe", {28'd0, bcast_xfc}, 32'd0);
        chk("uf_data_captured", bcast_data, 32'h33333333);
        @(negedge clk);
        chk("uf_sticky", {31'd0, rd_underflow}, 32'd1);

        // Reset mid-burst: outputs clear at once, req 0 regains priority
        @(posedge clk); #1;
        req_rts = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        chk("mid_burst_active", {28'd0, req_rtr, 3'd0, mem_rts}, {28'd0, 4'b0010, 4'b0001});
        #1;
        rst = 1'b1;
        #1;
        chk_idle_outputs("mid_rst");
        chk("mid_rst_underflow", {31'd0, rd_underflow}, 32'd0);
        chk("mid_rst_bcast", {bcast_data[31:4], bcast_data[3:0] | bcast_xfc}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_rts = 4'b1111;
        @(negedge clk);
        chk("post_rst_bubble", {31'd0, mem_rts}, 32'd0);
        @(negedge clk);
        chk("post_rst_req0_first", {28'd0, req_rtr}, 32'h1);
        chk("post_rst_addr", {16'd0, mem_addr}, 32'h0A00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
